multicycle_cu: RTL and testbench

//  Parametrised multi-cycle control unit for the accumulator CPU; replaces the single-cycle opcode decoder.

---
 rtl/cu_pkg.sv | 53 +++++
 rtl/cu_decoder.sv | 51 +++++
 rtl/multicycle_cu.sv | 157 +++++++++++++++
 tb/tb_multicycle_cu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types for the multi-cycle accumulator CPU control unit:
// opcodes, ALU function codes, FSM states and the decoded control bundle.
package cu_pkg;

    localparam int OP_CLA = 1;
    localparam int OP_COM = 2;
    localparam int OP_SHR = 3;
    localparam int OP_CSL = 4;
    localparam int OP_STP = 5;
    localparam int OP_ADD = 6;
    localparam int OP_STA = 7;
    localparam int OP_LDA = 8;
    localparam int OP_JMP = 9;
    localparam int OP_BAN = 10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_CSL = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;
    localparam logic [2:0] ALU_COM = 3'b110;

    localparam logic [1:0] SEL_MEM = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] sel12;
        logic [1:0] sel34;
        logic       is_cla;
        logic       is_alu;
        logic       is_jmp;
        logic       is_ban;
        logic       is_stp;
        logic       is_add;
        logic       is_lda;
        logic       is_sta;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_mem_op(input ctrl_t c);
        return c.is_add | c.is_lda | c.is_sta;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: opcode -> control bundle.
// Unknown opcodes come out with only the illegal flag set.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] op,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (op)
            OPW'(OP_CLA): ctrl.is_cla = 1'b1;
            OPW'(OP_COM): begin
                ctrl.is_alu = 1'b1;
                ctrl.alu_op = ALU_COM;
                ctrl.sel12  = SEL_ALU;
            end
            OPW'(OP_SHR): begin
                ctrl.is_alu = 1'b1;
                ctrl.alu_op = ALU_SHR;
                ctrl.sel12  = SEL_ALU;
            end
            OPW'(OP_CSL): begin
                ctrl.is_alu = 1'b1;
                ctrl.alu_op = ALU_CSL;
                ctrl.sel12  = SEL_ALU;
            end
            OPW'(OP_STP): ctrl.is_stp = 1'b1;
            OPW'(OP_ADD): begin
                ctrl.is_add = 1'b1;
                ctrl.alu_op = ALU_ADD;
                ctrl.sel12  = SEL_ALU;
            end
            OPW'(OP_STA): ctrl.is_sta = 1'b1;
            OPW'(OP_LDA): begin
                ctrl.is_lda = 1'b1;
                ctrl.sel12  = SEL_MEM;
            end
            OPW'(OP_JMP): ctrl.is_jmp = 1'b1;
            OPW'(OP_BAN): begin
                ctrl.is_ban = 1'b1;
                ctrl.sel34  = SEL_ALU;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memory timeout.
// Define MULTICYCLE_CU_ILLEGAL_TRAP_EN to halt with err on undefined opcodes.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int ALU_OPW = 3,
    parameter int SEL_W   = 2,
    parameter int MEM_TO  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OPW-1:0]     ir_in,
    input  logic               acc_neg,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               pc_rst,
    output logic               acc_wr_en,
    output logic               acc_rst,
    output logic [ALU_OPW-1:0] alu_op,
    output logic               alu_carry_in,
    output logic [SEL_W-1:0]   mux1_select,
    output logic [SEL_W-1:0]   mux2_select,
    output logic [SEL_W-1:0]   mux3_select,
    output logic [SEL_W-1:0]   mux4_select,
    output logic               halted,
    output logic               err,
    output logic [2:0]         state
);

    state_e     cur;
    state_e     nxt;
    ctrl_t      dec;
    ctrl_t      ctrl_q;
    logic [7:0] wait_cnt;
    logic       timeout;
    logic       err_set;
    logic       err_clr;
    logic       unused_bits;

    cu_decoder #(.OPW(OPW)) u_dec (
        .op   (ir_in),
        .ctrl (dec)
    );

    assign timeout      = (wait_cnt == 8'(MEM_TO - 1));
    assign alu_op       = ALU_OPW'(ctrl_q.alu_op);
    assign mux1_select  = SEL_W'(ctrl_q.sel12);
    assign mux2_select  = SEL_W'(ctrl_q.sel12);
    assign mux3_select  = SEL_W'(ctrl_q.sel34);
    assign mux4_select  = SEL_W'(ctrl_q.sel34);
    assign alu_carry_in = 1'b0;
    assign halted       = (cur == S_HALT);
    assign state        = cur;
    assign unused_bits  = ^{ctrl_q.is_stp, ctrl_q.illegal, dec.illegal};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= S_IDLE;
            ctrl_q   <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE)
                ctrl_q <= dec;
            // restart the wait count on every entry to an access state
            if (nxt != cur)
                wait_cnt <= '0;
            else if (cur == S_FETCH || cur == S_MEM)
                wait_cnt <= wait_cnt + 8'd1;
            if (err_set)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

    always_comb begin
        nxt       = cur;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_rst    = 1'b0;
        acc_wr_en = 1'b0;
        acc_rst   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        unique case (cur)
            S_IDLE: begin
                if (start)
                    nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    nxt     = S_DECODE;
                end else if (timeout) begin
                    err_set = 1'b1;
                    nxt     = S_HALT;
                end
            end
            S_DECODE: begin
                if (dec.is_stp) begin
                    pc_rst = 1'b1;
                    nxt    = S_HALT;
                end
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
                else if (dec.illegal) begin
                    err_set = 1'b1;
                    nxt     = S_HALT;
                end
`endif
                else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                acc_rst   = ctrl_q.is_cla;
                acc_wr_en = ctrl_q.is_alu;
                pc_load   = ctrl_q.is_jmp | (ctrl_q.is_ban & acc_neg);
                nxt       = is_mem_op(ctrl_q) ? S_MEM : S_FETCH;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = ctrl_q.is_sta;
                if (mem_ack) begin
                    nxt = ctrl_q.is_sta ? S_FETCH : S_WB;
                end else if (timeout) begin
                    err_set = 1'b1;
                    nxt     = S_HALT;
                end
            end
            S_WB: begin
                acc_wr_en = 1'b1;
                nxt       = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    err_clr = 1'b1;
                    nxt     = S_FETCH;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: an instruction-level model expands each
// instruction into per-cycle expectations that are checked every cycle.
module tb_multicycle_cu;

    localparam int MEM_TO = 15;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] ir_in;
    logic       acc_neg;
    logic       mem_ack;
    logic       mem_req, mem_we, ir_load, pc_inc, pc_load, pc_rst;
    logic       acc_wr_en, acc_rst, alu_carry_in, halted, err;
    logic [2:0] alu_op;
    logic [1:0] mux1_select, mux2_select, mux3_select, mux4_select;
    logic [2:0] state;

    multicycle_cu #(
        .OPW(6), .ALU_OPW(3), .SEL_W(2), .MEM_TO(MEM_TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ir_in(ir_in),
        .acc_neg(acc_neg), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_rst(pc_rst),
        .acc_wr_en(acc_wr_en), .acc_rst(acc_rst), .alu_op(alu_op),
        .alu_carry_in(alu_carry_in),
        .mux1_select(mux1_select), .mux2_select(mux2_select),
        .mux3_select(mux3_select), .mux4_select(mux4_select),
        .halted(halted), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, ack, neg;
        logic [5:0] ir;
        logic [2:0] st;
        logic       mem_req, mem_we, ir_load, pc_inc;
        logic       pc_load, pc_rst, acc_wr_en, acc_rst;
        logic [2:0] alu;
        logic [1:0] s12, s34;
        logic       err;
    } cyc_t;

    cyc_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [5:0] cur_ir;
    logic       cur_neg;
    logic [2:0] m_alu;
    logic [1:0] m_s12, m_s34;
    logic       m_err;

    int         acc_wr_cnt = 0;
    int         pc_load_cnt = 0;
    int         pc_rst_cnt = 0;
    int         since = 0;
    int         last_len = 0;
    logic [2:0] prev_st = 3'd0;
    logic [1:0] last_wr_mux1 = 2'd3;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", n, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            cyc_t e;
            e = exp_q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("mem_req", 32'(mem_req), 32'(e.mem_req));
            chk("mem_we", 32'(mem_we), 32'(e.mem_we));
            chk("ir_load", 32'(ir_load), 32'(e.ir_load));
            chk("pc_inc", 32'(pc_inc), 32'(e.pc_inc));
            chk("pc_load", 32'(pc_load), 32'(e.pc_load));
            chk("pc_rst", 32'(pc_rst), 32'(e.pc_rst));
            chk("acc_wr_en", 32'(acc_wr_en), 32'(e.acc_wr_en));
            chk("acc_rst", 32'(acc_rst), 32'(e.acc_rst));
            chk("alu_op", 32'(alu_op), 32'(e.alu));
            chk("alu_carry_in", 32'(alu_carry_in), 32'd0);
            chk("mux1", 32'(mux1_select), 32'(e.s12));
            chk("mux2", 32'(mux2_select), 32'(e.s12));
            chk("mux3", 32'(mux3_select), 32'(e.s34));
            chk("mux4", 32'(mux4_select), 32'(e.s34));
            chk("halted", 32'(halted), 32'(e.st == ST_HALT));
            chk("err", 32'(err), 32'(e.err));
        end
        if (acc_wr_en) begin
            acc_wr_cnt++;
            last_wr_mux1 = mux1_select;
        end
        if (pc_load) pc_load_cnt++;
        if (pc_rst) pc_rst_cnt++;
        if (state == ST_FETCH && prev_st != ST_FETCH) begin
            last_len = since;
            since = 1;
        end else begin
            since++;
        end
        prev_st = state;
    end

    function automatic cyc_t blank();
        cyc_t c;
        c = '{default: '0};
        c.ir  = cur_ir;
        c.neg = cur_neg;
        return c;
    endfunction

    task automatic step(input cyc_t c);
        rst     = c.rst;
        start   = c.start;
        mem_ack = c.ack;
        acc_neg = c.neg;
        ir_in   = c.ir;
        if (c.rst) begin
            m_alu = '0; m_s12 = '0; m_s34 = '0; m_err = 1'b0;
        end
        c.alu = m_alu;
        c.s12 = m_s12;
        c.s34 = m_s34;
        c.err = m_err;
        exp_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic tbl(input logic [5:0] op, output logic [2:0] a,
                       output logic [1:0] s12, output logic [1:0] s34);
        a = 3'b000; s12 = 2'b00; s34 = 2'b00;
        case (op)
            6'd2:  begin a = 3'b110; s12 = 2'b01; end
            6'd3:  begin a = 3'b101; s12 = 2'b01; end
            6'd4:  begin a = 3'b100; s12 = 2'b01; end
            6'd6:  begin a = 3'b000; s12 = 2'b01; end
            6'd10: s34 = 2'b01;
            default: ;
        endcase
    endtask

    task automatic rst_cyc(input logic ack);
        cyc_t c;
        c = blank();
        c.rst = 1'b1;
        c.ack = ack;
        c.st  = ST_IDLE;
        step(c);
    endtask

    task automatic idle_cyc(input logic s);
        cyc_t c;
        c = blank();
        c.start = s;
        c.st    = ST_IDLE;
        step(c);
    endtask

    task automatic halt_cyc(input logic s);
        cyc_t c;
        c = blank();
        c.start = s;
        c.st    = ST_HALT;
        step(c);
        if (s) m_err = 1'b0;
    endtask

    // fw/mw: wait cycles before ack; >= MEM_TO means never ack (timeout);
    // mw < 0 stops after one unacknowledged MEM cycle.
    task automatic instr(input logic [5:0] op, input int fw, input int mw,
                         input logic neg, input logic stray);
        cyc_t       c;
        logic [2:0] a;
        logic [1:0] s12, s34;
        cur_ir  = op;
        cur_neg = neg;
        for (int i = 0; i < fw && i < MEM_TO; i++) begin
            c = blank(); c.st = ST_FETCH; c.mem_req = 1'b1; step(c);
        end
        if (fw >= MEM_TO) begin
            m_err = 1'b1;
            return;
        end
        c = blank(); c.st = ST_FETCH; c.mem_req = 1'b1; c.ack = 1'b1;
        c.ir_load = 1'b1; c.pc_inc = 1'b1;
        step(c);
        c = blank(); c.st = ST_DECODE; c.ack = stray;
        c.pc_rst = (op == 6'd5);
        step(c);
        tbl(op, a, s12, s34);
        m_alu = a; m_s12 = s12; m_s34 = s34;
        if (op == 6'd5) return;
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
        if (!(op inside {[6'd1:6'd10]})) begin
            m_err = 1'b1;
            return;
        end
`endif
        c = blank(); c.st = ST_EXEC; c.ack = stray;
        c.acc_rst   = (op == 6'd1);
        c.acc_wr_en = (op inside {6'd2, 6'd3, 6'd4});
        c.pc_load   = (op == 6'd9) || (op == 6'd10 && neg);
        step(c);
        if (!(op inside {6'd6, 6'd7, 6'd8})) return;
        if (mw < 0) begin
            c = blank(); c.st = ST_MEM; c.mem_req = 1'b1;
            c.mem_we = (op == 6'd7);
            step(c);
            return;
        end
        for (int i = 0; i < mw && i < MEM_TO; i++) begin
            c = blank(); c.st = ST_MEM; c.mem_req = 1'b1;
            c.mem_we = (op == 6'd7);
            step(c);
        end
        if (mw >= MEM_TO) begin
            m_err = 1'b1;
            return;
        end
        c = blank(); c.st = ST_MEM; c.mem_req = 1'b1; c.ack = 1'b1;
        c.mem_we = (op == 6'd7);
        step(c);
        if (op == 6'd7) return;
        c = blank(); c.st = ST_WB; c.acc_wr_en = 1'b1;
        step(c);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; acc_neg = 1'b0;
        ir_in = '0; cur_ir = '0; cur_neg = 1'b0;
        m_alu = '0; m_s12 = '0; m_s34 = '0; m_err = 1'b0;
        @(posedge clk);
        #1;
        rst_cyc(1'b0);
        rst_cyc(1'b1);
        idle_cyc(1'b0);
        idle_cyc(1'b1);

        instr(6'd8, 2, 2, 1'b0, 1'b0);
        chk("lda_wr_count", 32'(acc_wr_cnt), 32'd1);
        chk("lda_wb_mux1", 32'(last_wr_mux1), 32'd0);
        instr(6'd6, 2, 2, 1'b0, 1'b0);
        chk("add_wr_count", 32'(acc_wr_cnt), 32'd2);
        chk("add_wb_mux1", 32'(last_wr_mux1), 32'd1);
        instr(6'd2, 0, 0, 1'b0, 1'b0);
        chk("add_latency", 32'(last_len), 32'd9);
        instr(6'd3, 0, 0, 1'b0, 1'b1);
        chk("com_latency", 32'(last_len), 32'd3);
        instr(6'd4, 1, 0, 1'b0, 1'b0);
        instr(6'd1, 0, 0, 1'b0, 1'b1);
        instr(6'd9, 0, 0, 1'b0, 1'b0);
        instr(6'd10, 0, 0, 1'b1, 1'b0);
        chk("ban_taken", 32'(pc_load_cnt), 32'd2);
        instr(6'd10, 0, 0, 1'b0, 1'b0);
        chk("ban_not_taken", 32'(pc_load_cnt), 32'd2);
        instr(6'd7, 0, 3, 1'b0, 1'b0);
        chk("sta_no_acc_wr", 32'(acc_wr_cnt), 32'd5);

        instr(6'd63, 0, 0, 1'b0, 1'b0);
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
        halt_cyc(1'b1);
`endif
        instr(6'd1, MEM_TO - 1, 0, 1'b0, 1'b0);
        instr(6'd1, MEM_TO, 0, 1'b0, 1'b0);
        halt_cyc(1'b0);
        halt_cyc(1'b1);
        instr(6'd8, 0, MEM_TO, 1'b0, 1'b0);
        halt_cyc(1'b1);

        instr(6'd5, 0, 0, 1'b0, 1'b0);
        chk("stp_pc_rst", 32'(pc_rst_cnt), 32'd1);
        halt_cyc(1'b0);
        halt_cyc(1'b1);

        instr(6'd6, 1, -1, 1'b0, 1'b0);
        rst_cyc(1'b1);
        idle_cyc(1'b0);
        idle_cyc(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
